// File: rtl/codec_pkg.sv
// Shared constants and types for the codec serial interface (frame counter, sample width, strobe phases).
// Latency: none; definitions only.
// Backpressure: none; the codec link is free-running and never stalls.
package codec_pkg;

  localparam int CNT_W  = 10;
  localparam int SMPL_W = 16;
  localparam int IDX_W  = 5;

  typedef logic [CNT_W-1:0]         cnt_t;
  typedef logic signed [SMPL_W-1:0] smpl_t;
  typedef logic [IDX_W-1:0]         idx_t;

  // Frame counter landmarks: reset point (start of left half), transmit
  // shadow load (last clk of the frame), and the clk that shows valid.
  localparam cnt_t CNT_RST   = 10'h200;
  localparam cnt_t TX_LOAD   = 10'h1FF;
  localparam cnt_t VALID_CNT = 10'h10A;

  // Phases inside one 16-clk SCLK period: SDout moves as SCLK falls,
  // SDin is captured while SCLK is high.
  localparam logic [3:0] SHIFT_PH = 4'hF;
  localparam logic [3:0] SAMP_PH  = 4'h9;

  // Data bit slots within a channel half (I2S one-bit delay after LRCLK).
  localparam idx_t FIRST_IDX = 5'd1;
  localparam idx_t LAST_IDX  = 5'd16;

  function automatic logic is_data_idx(idx_t idx);
    return (idx >= FIRST_IDX) && (idx <= LAST_IDX);
  endfunction

endpackage

// File: rtl/codec_if.sv
// Bundle of core-side sample ports and codec-side serial pins.
// Latency: none; wiring only.
// Backpressure: none; valid is a pulse with no ready.
interface codec_if;
  import codec_pkg::*;

  smpl_t lft_out;
  smpl_t rht_out;
  smpl_t lft_in;
  smpl_t rht_in;
  logic  valid;
  logic  LRCLK;
  logic  SCLK;
  logic  MCLK;
  logic  RSTn;
  logic  SDout;
  logic  SDin;

  // slave: the interface block itself
  modport slave (
    input  lft_out, rht_out, SDin,
    output lft_in, rht_in, valid, LRCLK, SCLK, MCLK, RSTn, SDout
  );

  // master: the core/codec environment around the block
  modport master (
    output lft_out, rht_out, SDin,
    input  lft_in, rht_in, valid, LRCLK, SCLK, MCLK, RSTn, SDout
  );

endinterface

// File: rtl/codec_shreg.sv
// 16-bit shift register: parallel load, serial in at LSB, serial out from MSB, shift enable.
// Latency: one clk from load/enable to new contents.
// Backpressure: none; load wins over shift when both are asserted.
module codec_shreg
  import codec_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  smpl_t i_ld_dat,
  input  logic  i_en,
  input  logic  i_sin,
  output logic  o_sout,
  output smpl_t o_par
);

  smpl_t r_sh;

  // Load has priority; a shift pushes MSB out first and takes the new bit at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_ld_dat;
    end else if (i_en) begin
      r_sh <= {r_sh[SMPL_W-2:0], i_sin};
    end
  end

  assign o_sout = r_sh[SMPL_W-1];
  assign o_par  = r_sh;

endmodule

// File: rtl/codec_intf.sv
// I2S-style codec interface: 1024-clk frame, 16-bit left/right samples out on SDout and in from SDin.
// Latency: tx sample appears on SDout from the frame after its 0x1FF load; rx pair presented at cnt 0x10A.
// Backpressure: none; free-running. Build macro CODEC_LOOPBACK_EN feeds internal SDout back to the receiver.
module codec_intf
  import codec_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  codec_if.slave bus
);

  cnt_t  r_cnt;
  logic  r_lrclk;
  logic  r_sclk;
  logic  r_mclk;
  logic  r_rstn;
  logic  r_sdout;
  logic  r_valid;
  logic  r_armed;
  smpl_t r_lft_in;
  smpl_t r_rht_in;

  cnt_t  w_cnt_inc;
  idx_t  w_idx;
  idx_t  w_nidx;
  logic  w_shift_ph;
  logic  w_samp_ph;
  logic  w_tx_load;
  logic  w_tx_act;
  logic  w_tx_l_en;
  logic  w_tx_r_en;
  logic  w_tx_l_sout;
  logic  w_tx_r_sout;
  logic  w_tx_bit;
  logic  w_rx_act;
  logic  w_rx_l_en;
  logic  w_rx_r_en;
  logic  w_rx_bit;
  logic  w_rx_done;
  smpl_t w_rx_l_par;
  smpl_t w_rx_r_par;
  smpl_t w_tx_l_par_unused;
  smpl_t w_tx_r_par_unused;
  logic  w_rx_l_sout_unused;
  logic  w_rx_r_sout_unused;

  // Transmit works on the slot about to start (cnt+1); receive on the slot in progress.
  assign w_cnt_inc  = r_cnt + cnt_t'(1);
  assign w_idx      = r_cnt[8:4];
  assign w_nidx     = w_cnt_inc[8:4];
  assign w_shift_ph = (r_cnt[3:0] == SHIFT_PH);
  assign w_samp_ph  = (r_cnt[3:0] == SAMP_PH);
  assign w_tx_load  = (r_cnt == TX_LOAD);

  assign w_tx_act  = w_shift_ph && is_data_idx(w_nidx);
  assign w_tx_l_en = w_tx_act && w_cnt_inc[9];
  assign w_tx_r_en = w_tx_act && !w_cnt_inc[9];
  assign w_tx_bit  = w_cnt_inc[9] ? w_tx_l_sout : w_tx_r_sout;

  assign w_rx_act  = w_samp_ph && is_data_idx(w_idx);
  assign w_rx_l_en = w_rx_act && r_lrclk;
  assign w_rx_r_en = w_rx_act && !r_lrclk;

  // The clk that samples the 16th right bit; the pair goes out on the next clk.
  assign w_rx_done = (w_cnt_inc == VALID_CNT);

`ifdef CODEC_LOOPBACK_EN
  assign w_rx_bit = r_sdout;
`else
  assign w_rx_bit = bus.SDin;
`endif

  codec_shreg u_tx_l (
    .clk(clk), .rst(rst), .i_load(w_tx_load), .i_ld_dat(bus.lft_out),
    .i_en(w_tx_l_en), .i_sin(1'b0), .o_sout(w_tx_l_sout), .o_par(w_tx_l_par_unused)
  );

  codec_shreg u_tx_r (
    .clk(clk), .rst(rst), .i_load(w_tx_load), .i_ld_dat(bus.rht_out),
    .i_en(w_tx_r_en), .i_sin(1'b0), .o_sout(w_tx_r_sout), .o_par(w_tx_r_par_unused)
  );

  codec_shreg u_rx_l (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_ld_dat('0),
    .i_en(w_rx_l_en), .i_sin(w_rx_bit), .o_sout(w_rx_l_sout_unused), .o_par(w_rx_l_par)
  );

  codec_shreg u_rx_r (
    .clk(clk), .rst(rst), .i_load(1'b0), .i_ld_dat('0),
    .i_en(w_rx_r_en), .i_sin(w_rx_bit), .o_sout(w_rx_r_sout_unused), .o_par(w_rx_r_par)
  );

  // Free-running frame counter; clock pins are flopped from its next value so they track cnt glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= CNT_RST;
      r_lrclk <= CNT_RST[9];
      r_sclk  <= CNT_RST[3];
      r_mclk  <= CNT_RST[1];
      r_rstn  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_inc;
      r_lrclk <= w_cnt_inc[9];
      r_sclk  <= w_cnt_inc[3];
      r_mclk  <= w_cnt_inc[1];
      r_rstn  <= 1'b1;
    end
  end

  // SDout changes only as SCLK falls: next data bit inside idx 1..16, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdout <= 1'b0;
    end else if (w_shift_ph) begin
      r_sdout <= is_data_idx(w_nidx) ? w_tx_bit : 1'b0;
    end
  end

  // Present the received pair once per frame. The receiver is only armed after passing a
  // frame boundary (0x1FF), so the half-frame straight after reset is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_armed  <= 1'b0;
      r_lft_in <= '0;
      r_rht_in <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_tx_load) begin
        r_armed <= 1'b1;
      end
      if (w_rx_done && r_armed) begin
        r_valid  <= 1'b1;
        r_lft_in <= w_rx_l_par;
        r_rht_in <= {w_rx_r_par[SMPL_W-2:0], w_rx_bit};
      end
    end
  end

  assign bus.LRCLK  = r_lrclk;
  assign bus.SCLK   = r_sclk;
  assign bus.MCLK   = r_mclk;
  assign bus.RSTn   = r_rstn;
  assign bus.SDout  = r_sdout;
  assign bus.valid  = r_valid;
  assign bus.lft_in = r_lft_in;
  assign bus.rht_in = r_rht_in;

endmodule

// File: doc/codec_intf.md
CODEC_INTF -- requirements
Module: codec_intf

Interface
REQ-001 The block SHALL have one clock `clk`, and all state SHALL be updated on its rising edge.
REQ-002 Reset `rst` SHALL be synchronous and active-high.
REQ-003 Ports, as name, direction, width, meaning:
- clk  in  1  system clock
- rst  in  1  sync active-high reset
- lft_out  in  16  signed equalized left sample from the digital core
- rht_out  in  16  signed equalized right sample from the digital core
- lft_in  out  16  signed received left sample to the digital core
- rht_in  out  16  signed received right sample to the digital core
- valid  out  1  one-clk pulse: new lft_in/rht_in pair present
- LRCLK  out  1  frame clock; 1 = left half, 0 = right half
- SCLK  out  1  serial bit clock
- MCLK  out  1  codec master clock
- RSTn  out  1  codec reset, active-low
- SDout  out  1  serial data to the codec DAC
- SDin  in  1  serial data from the codec ADC

Function
REQ-004 A free-running 10-bit counter `cnt` SHALL increment every clk and wrap from 0x3FF to 0x000.
REQ-005 The clock outputs SHALL be registered copies of counter bits, so there is no combinational glitch: LRCLK=cnt[9], SCLK=cnt[3], MCLK=cnt[1].
- This gives 1024 clk per frame, 64 SCLK per frame, 32 SCLK per channel half.
REQ-006 The SCLK index within a half SHALL be idx=cnt[8:4] (0..31).
REQ-007 Data SHALL occupy idx 1..16, MSB first, in I2S style with a one-bit delay after the LRCLK edge.
- At idx 0 and idx 17..31, SDout SHALL be 0 and SDin SHALL be ignored.
REQ-008 Transmit load: when cnt==0x1FF, lft_out and rht_out SHALL be captured into transmit shadow registers.
- Core outputs may change at any other time without affecting the frame in progress.
REQ-009 Transmit shift: SDout SHALL change only in the clk where cnt[3:0]==0xF, i.e. one clk before SCLK falls.
- The first left bit SHALL be driven at cnt==0x20F; the first right bit at cnt==0x00F.
REQ-010 Receive: SDin SHALL be sampled when cnt[3:0]==0x9 (SCLK high) for idx 1..16 of each half.
- Samples SHALL shift into the left or right receive shift register selected by LRCLK.
REQ-011 valid SHALL pulse high for exactly one clk at cnt==0x10A, the clk after the 16th right bit is sampled.
- lft_in and rht_in SHALL update in that same clk and SHALL hold until the next valid, 1024 clk later.
REQ-012 The first valid after reset SHALL occur only after one complete left half plus right half has been received.
- A partial frame SHALL never produce valid.

Reset
REQ-013 While rst is high, the following SHALL hold:
- cnt=0x200, so LRCLK=1 on exit from reset;
- SCLK=0, MCLK=0, SDout=0, valid=0;
- lft_in=rht_in=0, and all shift and shadow registers are 0;
- RSTn=0.
REQ-014 RSTn SHALL go high one clk after rst deasserts.
REQ-015 Asserting rst mid-frame SHALL abort the frame, and valid SHALL not fire for the aborted data.

Configuration
REQ-016 The macro CODEC_LOOPBACK_EN SHALL select between two receive sources.
- Defined: the receive path SHALL sample the internal SDout instead of the SDin pin, and SDin SHALL be unused. Timing is unchanged.
- Undefined: the receive path SHALL sample SDin exactly as specified above.

Structure
REQ-017 A shared package codec_pkg SHALL hold the following:
- CNT_W=10 and SMPL_W=16;
- CNT_RST=10'h200, TX_LOAD=10'h1FF, VALID_CNT=10'h10A;
- the strobe phases SHIFT_PH=4'hF and SAMP_PH=4'h9;
- the data index bounds FIRST_IDX=1 and LAST_IDX=16.
REQ-018 A 16-bit shift register sub-module codec_shreg, with parallel load, serial in, serial out and enable, SHALL be instantiated four times: tx left, tx right, rx left, rx right.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset: rst high for 3 clk -> LRCLK=1, SCLK=MCLK=SDout=valid=RSTn=0, lft_in=rht_in=0; after release, RSTn=1 after 1 clk.
- Ratios: count 1024 clk after reset -> exactly 1 LRCLK period, 64 SCLK periods, 256 MCLK periods; no valid in the first partial frame.
- Receive: drive SDin I2S with left=0xA5C3, right=0x8001 -> valid for exactly 1 clk at cnt==0x10A, lft_in=0xA5C3, rht_in=0x8001, held 1024 clk.
- Transmit: hold lft_out=0x1234, rht_out=0xFEDC -> SDout decodes 0x1234 at left idx 1..16 and 0xFEDC at right idx 1..16, 0 at idx 0 and 17..31; changing inputs mid-frame has no effect until the next 0x1FF load.
- Loopback (CODEC_LOOPBACK_EN defined): lft_out=0x7FFF, rht_out=0x0000 -> the valid following the first full transmitted frame gives lft_in=0x7FFF, rht_in=0x0000.
- Mid-frame reset: rst for 1 clk at cnt==0x305 -> cnt restarts at 0x200, no valid at the next 0x10A, first valid one full frame later with correct data.
